// File: rtl/program_memory_arbiter.sv
// Shares the program memory between fetch and loader. Read data arrives 2 cycles after accept, with an owner tag; there is no backpressure, only per-cycle grants.
// Define ARBITER_ROUND_ROBIN_EN to alternate grants on conflicts. Otherwise the loader always wins.
module program_memory_arbiter #(
    parameter int DATA_WIDTH    = 16,
    parameter int ADDRESS_WIDTH = 16,
    parameter int DEPTH         = 2048
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     fetch_req,
    input  logic [0:ADDRESS_WIDTH-1] fetch_address,
    output logic                     fetch_gnt,
    output logic                     fetch_rvalid,
    input  logic                     loader_req,
    input  logic                     loader_write,
    input  logic [0:ADDRESS_WIDTH-1] loader_address,
    input  logic [0:DATA_WIDTH-1]    loader_wdata,
    input  logic                     loader_lock,
    output logic                     loader_gnt,
    output logic                     loader_rvalid,
    output logic [0:DATA_WIDTH-1]    rdata,
    output logic                     addr_error,
    output logic [0:ADDRESS_WIDTH-1] mem_address,
    output logic                     mem_write_enable,
    output logic [0:DATA_WIDTH-1]    mem_write_data,
    input  logic [0:DATA_WIDTH-1]    mem_read_data
);

    typedef enum logic {ST_OPEN, ST_LOCKED} lock_state_t;

    localparam logic OWNER_FETCH  = 1'b0;
    localparam logic OWNER_LOADER = 1'b1;
    localparam logic [ADDRESS_WIDTH-1:0] LP_DEPTH = ADDRESS_WIDTH'(DEPTH);

    lock_state_t r_state;
    lock_state_t w_state_nxt;
    logic        r_last_winner;

    logic r_s1_vld, r_s1_owner, r_s1_err;
    logic r_s2_vld, r_s2_owner, r_s2_err;

    logic [0:ADDRESS_WIDTH-1] r_mem_address;
    logic                     r_mem_we;
    logic [0:DATA_WIDTH-1]    r_mem_wdata;

    logic                     w_fetch_gnt;
    logic                     w_loader_gnt;
    logic                     w_accept;
    logic                     w_in_range;
    logic                     w_is_read;
    logic [0:ADDRESS_WIDTH-1] w_addr;

`ifndef ARBITER_ROUND_ROBIN_EN
    logic w_unused_last_winner;
    assign w_unused_last_winner = r_last_winner;
`endif

    always_comb begin
        w_fetch_gnt  = 1'b0;
        w_loader_gnt = 1'b0;
        w_state_nxt  = r_state;
        case (r_state)
            ST_OPEN: begin
                if (fetch_req && loader_req) begin
`ifdef ARBITER_ROUND_ROBIN_EN
                    w_loader_gnt = (r_last_winner == OWNER_FETCH);
                    w_fetch_gnt  = ~w_loader_gnt;
`else
                    w_loader_gnt = 1'b1;
`endif
                end else begin
                    w_fetch_gnt  = fetch_req;
                    w_loader_gnt = loader_req;
                end
                if (w_loader_gnt && loader_lock) begin
                    w_state_nxt = ST_LOCKED;
                end
            end
            ST_LOCKED: begin
                w_loader_gnt = loader_req;
                if (!loader_lock) begin
                    w_state_nxt = ST_OPEN;
                end
            end
            default: w_state_nxt = ST_OPEN;
        endcase
    end

    assign w_accept   = w_fetch_gnt | w_loader_gnt;
    assign w_addr     = w_loader_gnt ? loader_address : fetch_address;
    assign w_in_range = (w_addr < LP_DEPTH);
    assign w_is_read  = w_fetch_gnt | (w_loader_gnt & ~loader_write);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= ST_OPEN;
            r_last_winner <= OWNER_LOADER;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_last_winner <= w_loader_gnt;
            end
        end
    end

    // The address holds between accesses; only the write strobe falls back to idle.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_mem_address <= '0;
            r_mem_we      <= 1'b0;
            r_mem_wdata   <= '0;
        end else begin
            r_mem_we <= 1'b0;
            if (w_accept) begin
                r_mem_address <= w_addr;
                r_mem_we      <= w_loader_gnt & loader_write & w_in_range;
                r_mem_wdata   <= loader_wdata;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_s1_vld   <= 1'b0;
            r_s1_owner <= OWNER_FETCH;
            r_s1_err   <= 1'b0;
            r_s2_vld   <= 1'b0;
            r_s2_owner <= OWNER_FETCH;
            r_s2_err   <= 1'b0;
        end else begin
            r_s1_vld   <= w_accept & w_is_read;
            r_s1_owner <= w_loader_gnt;
            r_s1_err   <= w_accept & ~w_in_range;
            r_s2_vld   <= r_s1_vld;
            r_s2_owner <= r_s1_owner;
            r_s2_err   <= r_s1_err;
        end
    end

    assign fetch_gnt        = w_fetch_gnt;
    assign loader_gnt       = w_loader_gnt;
    assign fetch_rvalid     = r_s2_vld & (r_s2_owner == OWNER_FETCH);
    assign loader_rvalid    = r_s2_vld & (r_s2_owner == OWNER_LOADER);
    assign addr_error       = r_s2_err;
    assign rdata            = (r_s2_vld && r_s2_err) ? '0 : mem_read_data;
    assign mem_address      = r_mem_address;
    assign mem_write_enable = r_mem_we;
    assign mem_write_data   = r_mem_wdata;

endmodule

// File: tb/tb_program_memory_arbiter.sv
// Directed bench for program_memory_arbiter: stimulus pushes expected responses and a monitor checks them.
// Expected grant order depends on ARBITER_ROUND_ROBIN_EN.
module tb_program_memory_arbiter;

    logic        clock;
    logic        reset_n;
    logic        fetch_req;
    logic [0:15] fetch_address;
    logic        fetch_gnt;
    logic        fetch_rvalid;
    logic        loader_req;
    logic        loader_write;
    logic [0:15] loader_address;
    logic [0:15] loader_wdata;
    logic        loader_lock;
    logic        loader_gnt;
    logic        loader_rvalid;
    logic [0:15] rdata;
    logic        addr_error;
    logic [0:15] mem_address;
    logic        mem_write_enable;
    logic [0:15] mem_write_data;
    logic [0:15] mem_read_data;

    program_memory_arbiter #(
        .DATA_WIDTH   (16),
        .ADDRESS_WIDTH(16),
        .DEPTH        (2048)
    ) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .fetch_req       (fetch_req),
        .fetch_address   (fetch_address),
        .fetch_gnt       (fetch_gnt),
        .fetch_rvalid    (fetch_rvalid),
        .loader_req      (loader_req),
        .loader_write    (loader_write),
        .loader_address  (loader_address),
        .loader_wdata    (loader_wdata),
        .loader_lock     (loader_lock),
        .loader_gnt      (loader_gnt),
        .loader_rvalid   (loader_rvalid),
        .rdata           (rdata),
        .addr_error      (addr_error),
        .mem_address     (mem_address),
        .mem_write_enable(mem_write_enable),
        .mem_write_data  (mem_write_data),
        .mem_read_data   (mem_read_data)
    );

    typedef struct {
        logic        rd;
        logic        owner;
        logic [15:0] data;
        logic        err;
        int          due;
    } exp_t;

    exp_t        sb_q[$];
    int          n_pass  = 0;
    int          n_total = 0;
    int          cyc_cnt = 0;
    logic [15:0] wmem [int];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc_cnt <= cyc_cnt + 1;

    // Memory model: unwritten words hold their own address; out-of-range reads return junk.
    always @(posedge clock) begin
        int a;
        a = int'(mem_address);
        if (a < 2048) mem_read_data <= wmem.exists(a) ? wmem[a] : a[15:0];
        else          mem_read_data <= 16'hDEAD;
        if (mem_write_enable) wmem[a] = mem_write_data;
    end

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    always @(negedge clock) begin
        exp_t e;
        if (reset_n && (fetch_rvalid || loader_rvalid || addr_error)) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_output", 1, 0);
            end else begin
                e = sb_q.pop_front();
                chk("resp_cycle", cyc_cnt, e.due);
                chk("fetch_rvalid", int'(fetch_rvalid), int'(e.rd && !e.owner));
                chk("loader_rvalid", int'(loader_rvalid), int'(e.rd && e.owner));
                chk("addr_error", int'(addr_error), int'(e.err));
                if (e.rd) chk("rdata", int'(rdata), int'(e.data));
            end
        end
    end

    // Called at a negedge: drives one cycle, checks grants, queues the expected response.
    task automatic cyc(input bit fr, input int fa, input bit lr, input bit lw, input int la,
                       input int lwd, input bit lk, input bit efg, input bit elg, input int edat);
        exp_t e;
        fetch_req      = fr;
        fetch_address  = fa[15:0];
        loader_req     = lr;
        loader_write   = lw;
        loader_address = la[15:0];
        loader_wdata   = lwd[15:0];
        loader_lock    = lk;
        #1;
        chk("fetch_gnt", int'(fetch_gnt), int'(efg));
        chk("loader_gnt", int'(loader_gnt), int'(elg));
        if (efg) begin
            e = '{1'b1, 1'b0, edat[15:0], fa >= 2048, cyc_cnt + 2};
            sb_q.push_back(e);
        end
        if (elg && (!lw || la >= 2048)) begin
            e = '{!lw, 1'b1, edat[15:0], la >= 2048, cyc_cnt + 2};
            sb_q.push_back(e);
        end
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic chk_reset_outputs();
        chk("rst_mem_we", int'(mem_write_enable), 0);
        chk("rst_mem_address", int'(mem_address), 0);
        chk("rst_mem_wdata", int'(mem_write_data), 0);
        chk("rst_fetch_rvalid", int'(fetch_rvalid), 0);
        chk("rst_loader_rvalid", int'(loader_rvalid), 0);
        chk("rst_addr_error", int'(addr_error), 0);
    endtask

    initial begin
        reset_n = 1'b0;
        fetch_req = 0; fetch_address = 0;
        loader_req = 0; loader_write = 0; loader_address = 0; loader_wdata = 0; loader_lock = 0;
        @(negedge clock);
        @(negedge clock);
        chk_reset_outputs();
        reset_n = 1'b1;

        // Single fetch read.
        cyc(1, 3, 0, 0, 0, 0, 0, 1, 0, 3);
        chk("t1_mem_address", int'(mem_address), 3);
        chk("t1_mem_we", int'(mem_write_enable), 0);
        idle(2);

        // Both requesting for 6 cycles; last winner so far is fetch.
        for (int i = 0; i < 6; i++) begin
`ifdef ARBITER_ROUND_ROBIN_EN
            cyc(1, 1, 1, 0, 2, 0, 0, (i % 2) == 1, (i % 2) == 0, ((i % 2) == 1) ? 1 : 2);
`else
            cyc(1, 1, 1, 0, 2, 0, 0, 0, 1, 2);
`endif
        end
        idle(2);

        // Locked write then read-back; fetch is refused while locked.
        cyc(0, 0, 1, 1, 'h10, 'hBEEF, 1, 0, 1, 0);
        chk("t3_mem_we", int'(mem_write_enable), 1);
        chk("t3_mem_address", int'(mem_address), 'h10);
        chk("t3_mem_wdata", int'(mem_write_data), 'hBEEF);
        cyc(1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        chk("t3_mem_we_drop", int'(mem_write_enable), 0);
        cyc(1, 0, 1, 0, 'h10, 0, 1, 0, 1, 'hBEEF);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(1);

        // Out-of-range read and write.
        cyc(1, 2048, 0, 0, 0, 0, 0, 1, 0, 0);
        cyc(0, 0, 1, 1, 4000, 'h1234, 0, 0, 1, 0);
        chk("t4_oor_write_we", int'(mem_write_enable), 0);
        idle(3);

        // Back-to-back fetch reads.
        for (int i = 0; i < 4; i++) cyc(1, i, 0, 0, 0, 0, 0, 1, 0, i);
        idle(3);

        // Enter LOCKED, then reset: lock must clear and an in-flight read must vanish.
        cyc(0, 0, 1, 0, 6, 0, 1, 0, 1, 6);
        cyc(1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        reset_n = 1'b0;
        fetch_req = 0; loader_req = 0; loader_lock = 0;
        #1;
        chk_reset_outputs();
        @(negedge clock);
        reset_n = 1'b1;
        fetch_req = 1; fetch_address = 16'd5;
        #1;
        chk("t6_gnt_after_reset", int'(fetch_gnt), 1);
        @(posedge clock);
        @(negedge clock);
        fetch_req = 0;
        reset_n = 1'b0;
        #1;
        chk("t6_midreset_mem_address", int'(mem_address), 0);
        chk("t6_midreset_fetch_rvalid", int'(fetch_rvalid), 0);
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        idle(4);

        chk("scoreboard_drained", sb_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
